game_flow_fsm: RTL and testbench

Frame-rate game controller that owns lives, power-pellet (reversal) mode, fruit and ghost enables, and the win/lose outcome. Sits downstream of the ghost/fruit proximity checks (ghost_pacman_distance and the fruit distance compares) and the dot/score counter. Sits upstream of the pacman sprite, the three ghost modules and color_mapper, which consume its registered flags. Replaces the scattered VGA_VS-clocked logic with one synchronous FSM on the system clock.

---
 rtl/game_pkg.sv | 27 ++
 rtl/frame_timer.sv | 29 ++
 rtl/game_flow_fsm.sv | 156 +++++++++++++++
 tb/tb_game_flow_fsm.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller and the
// proximity checks feeding it.
package game_pkg;

    typedef enum logic [2:0] {
        READY,
        PLAY,
        POWER,
        DYING,
        GAMEOVER,
        WIN
    } game_state_t;

    // Bit positions in ghost_near / ghost_enable
    localparam int RED   = 0;
    localparam int GREEN = 1;
    localparam int AQUA  = 2;

    localparam int COLLIDE_R2 = 64;
    localparam int TIMER_W    = 10;

    // Isolates the lowest set bit: first fruit wins when several are near
    function automatic logic [2:0] lowest_bit(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter shared by the READY, DYING and POWER phases.
// Saturates at zero so an idle timer never wraps.
module frame_timer
    import game_pkg::*;
#(
    parameter int RESET_VALUE = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic               enable,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset)
            count <= TIMER_W'(RESET_VALUE);
        else if (load)
            count <= load_value;
        else if (enable && count != '0)
            count <= count - TIMER_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/game_flow_fsm.sv
// Frame-rate game controller: lives, power mode, fruit/ghost enables and
// the win/lose outcome, all registered on the system clock.
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 2,
    parameter int POWER_FRAMES = 600,
    parameter int DYING_FRAMES = 120,
    parameter int READY_FRAMES = 180,
    parameter int WIN_SCORE    = 150,
    parameter int SCORE_W      = 11
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [2:0]         ghost_near,
    input  logic [2:0]         fruit_near,
    input  logic               dots_clear,
    input  logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               reversal,
    output logic [2:0]         ghost_enable,
    output logic [2:0]         fruit_on,
    output logic               freeze,
    output logic               respawn,
    output logic               ghost_eaten,
    output logic               death,
    output logic               victory
);

    localparam logic [TIMER_W-1:0] READY_LOAD = TIMER_W'(READY_FRAMES - 1);
    localparam logic [TIMER_W-1:0] DYING_LOAD = TIMER_W'(DYING_FRAMES - 1);
    localparam logic [TIMER_W-1:0] POWER_LOAD = TIMER_W'(POWER_FRAMES - 1);

    game_state_t        state, state_d;
    logic [1:0]         lives_d;
    logic [2:0]         ghost_enable_d, fruit_on_d;
    logic               respawn_d, ghost_eaten_d;
    logic               timer_load, timer_zero;
    logic [TIMER_W-1:0] timer_load_value;

    logic       win_now;
    logic [2:0] live_hits, fruit_pick;

    assign win_now    = dots_clear || (score >= SCORE_W'(WIN_SCORE));
    assign live_hits  = ghost_near & ghost_enable;
    assign fruit_pick = lowest_bit(fruit_near & fruit_on);

    frame_timer #(
        .RESET_VALUE(READY_FRAMES - 1)
    ) u_frame_timer (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (timer_load),
        .enable    (frame_tick),
        .load_value(timer_load_value),
        .zero      (timer_zero)
    );

    always_comb begin
        state_d          = state;
        lives_d          = lives;
        ghost_enable_d   = ghost_enable;
        fruit_on_d       = fruit_on;
        respawn_d        = 1'b0;
        ghost_eaten_d    = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = READY_LOAD;

        if (frame_tick) begin
            case (state)
                READY: begin
                    if (timer_zero)
                        state_d = PLAY;
                end
                PLAY: begin
                    if (win_now) begin
                        state_d = WIN;
                    end else if (live_hits != 3'b000) begin
                        state_d          = DYING;
                        timer_load       = 1'b1;
                        timer_load_value = DYING_LOAD;
                    end else if (fruit_pick != 3'b000) begin
                        fruit_on_d       = fruit_on & ~fruit_pick;
                        state_d          = POWER;
                        timer_load       = 1'b1;
                        timer_load_value = POWER_LOAD;
                    end
                end
                POWER: begin
                    if (win_now) begin
                        state_d = WIN;
                    end else begin
                        if (live_hits != 3'b000) begin
                            ghost_enable_d = ghost_enable & ~live_hits;
                            ghost_eaten_d  = 1'b1;
                        end
                        // A fresh fruit extends power mode from this tick
                        if (fruit_pick != 3'b000) begin
                            fruit_on_d       = fruit_on & ~fruit_pick;
                            timer_load       = 1'b1;
                            timer_load_value = POWER_LOAD;
                        end else if (timer_zero) begin
                            state_d        = PLAY;
                            ghost_enable_d = 3'b111;
                        end
                    end
                end
                DYING: begin
                    if (timer_zero) begin
                        if (lives == 2'd0) begin
                            state_d = GAMEOVER;
                        end else begin
                            lives_d          = lives - 2'd1;
                            respawn_d        = 1'b1;
                            ghost_enable_d   = 3'b111;
                            state_d          = READY;
                            timer_load       = 1'b1;
                            timer_load_value = READY_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Flags are decoded from the next state so they change with the state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= READY;
            lives        <= 2'(LIVES_INIT);
            ghost_enable <= 3'b111;
            fruit_on     <= 3'b111;
            respawn      <= 1'b0;
            ghost_eaten  <= 1'b0;
            reversal     <= 1'b0;
            freeze       <= 1'b1;
            death        <= 1'b0;
            victory      <= 1'b0;
        end else begin
            state        <= state_d;
            lives        <= lives_d;
            ghost_enable <= ghost_enable_d;
            fruit_on     <= fruit_on_d;
            respawn      <= respawn_d;
            ghost_eaten  <= ghost_eaten_d;
            reversal     <= (state_d == POWER);
            freeze       <= (state_d == READY) || (state_d == DYING) ||
                            (state_d == GAMEOVER) || (state_d == WIN);
            death        <= (state_d == GAMEOVER);
            victory      <= (state_d == WIN);
        end
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: directed scenarios plus random play, every cycle
// compared against a deadline-based reference model.
module tb_game_flow_fsm;

    localparam int LIVES_INIT   = 2;
    localparam int POWER_FRAMES = 600;
    localparam int DYING_FRAMES = 120;
    localparam int READY_FRAMES = 180;
    localparam int WIN_SCORE    = 150;
    localparam int SCORE_W      = 11;

    localparam int M_READY = 0, M_PLAY = 1, M_POWER = 2, M_DYING = 3, M_OVER = 4, M_WIN = 5;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               frame_tick = 1'b0;
    logic [2:0]         ghost_near = '0;
    logic [2:0]         fruit_near = '0;
    logic               dots_clear = 1'b0;
    logic [SCORE_W-1:0] score = '0;
    logic [1:0]         lives;
    logic               reversal, freeze, respawn, ghost_eaten, death, victory;
    logic [2:0]         ghost_enable, fruit_on;

    int compared   = 0;
    int mismatched = 0;

    // Model: absolute tick number at which the current timed phase ends
    int         mMode, mTick, mDeadline, mLives;
    logic [2:0] mGhosts, mFruits;
    logic       mRespawn, mEaten;

    always #5 Clk = ~Clk;

    game_flow_fsm #(
        .LIVES_INIT  (LIVES_INIT),
        .POWER_FRAMES(POWER_FRAMES),
        .DYING_FRAMES(DYING_FRAMES),
        .READY_FRAMES(READY_FRAMES),
        .WIN_SCORE   (WIN_SCORE),
        .SCORE_W     (SCORE_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .ghost_near  (ghost_near),
        .fruit_near  (fruit_near),
        .dots_clear  (dots_clear),
        .score       (score),
        .lives       (lives),
        .reversal    (reversal),
        .ghost_enable(ghost_enable),
        .fruit_on    (fruit_on),
        .freeze      (freeze),
        .respawn     (respawn),
        .ghost_eaten (ghost_eaten),
        .death       (death),
        .victory     (victory)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [2:0] firstOf(input logic [2:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 2; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic modelReset();
        mMode     = M_READY;
        mTick     = 0;
        mDeadline = READY_FRAMES;
        mLives    = LIVES_INIT;
        mGhosts   = 3'b111;
        mFruits   = 3'b111;
        mRespawn  = 1'b0;
        mEaten    = 1'b0;
    endtask

    task automatic modelStep(input logic t, input logic rst, input logic [2:0] g, input logic [2:0] f,
                             input logic d, input int sc);
        logic       won;
        logic [2:0] pick, eaten;
        mRespawn = 1'b0;
        mEaten   = 1'b0;
        won      = d || (sc >= WIN_SCORE);
        pick     = firstOf(f & mFruits);
        eaten    = g & mGhosts;
        if (rst) begin
            modelReset();
        end else if (t) begin
            mTick++;
            case (mMode)
                M_READY: if (mTick == mDeadline) mMode = M_PLAY;
                M_PLAY: begin
                    if (won) mMode = M_WIN;
                    else if (eaten != 0) begin
                        mMode = M_DYING;
                        mDeadline = mTick + DYING_FRAMES;
                    end else if (pick != 0) begin
                        mFruits   = mFruits & ~pick;
                        mMode     = M_POWER;
                        mDeadline = mTick + POWER_FRAMES;
                    end
                end
                M_POWER: begin
                    if (won) mMode = M_WIN;
                    else begin
                        if (eaten != 0) begin
                            mGhosts = mGhosts & ~eaten;
                            mEaten  = 1'b1;
                        end
                        if (pick != 0) begin
                            mFruits   = mFruits & ~pick;
                            mDeadline = mTick + POWER_FRAMES;
                        end else if (mTick == mDeadline) begin
                            mMode   = M_PLAY;
                            mGhosts = 3'b111;
                        end
                    end
                end
                M_DYING: begin
                    if (mTick == mDeadline) begin
                        if (mLives == 0) mMode = M_OVER;
                        else begin
                            mLives    = mLives - 1;
                            mRespawn  = 1'b1;
                            mGhosts   = 3'b111;
                            mMode     = M_READY;
                            mDeadline = mTick + READY_FRAMES;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [13:0] expectedOuts();
        logic fz;
        fz = (mMode == M_READY) || (mMode == M_DYING) || (mMode == M_OVER) || (mMode == M_WIN);
        return {2'(mLives), mMode == M_POWER, mGhosts, mFruits, fz, mRespawn, mEaten,
                mMode == M_OVER, mMode == M_WIN};
    endfunction

    function automatic logic [13:0] actualOuts();
        return {lives, reversal, ghost_enable, fruit_on, freeze, respawn, ghost_eaten, death, victory};
    endfunction

    task automatic applyStimulus(input logic t, input logic rst, input logic [2:0] g, input logic [2:0] f,
                                 input logic d, input int sc);
        frame_tick = t;
        Reset      = rst;
        ghost_near = g;
        fruit_near = f;
        dots_clear = d;
        score      = SCORE_W'(sc);
        @(posedge Clk);
        modelStep(t, rst, g, f, d, sc);
        #1;
        checkOutput("cycle_outputs", 32'(actualOuts()), 32'(expectedOuts()));
    endtask

    task automatic tickIdle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 0);
    endtask

    initial begin
        doReset();
        checkOutput("reset_lives", 32'(lives), 2);
        checkOutput("reset_reversal", 32'(reversal), 0);
        checkOutput("reset_ghost_enable", 32'(ghost_enable), 7);
        checkOutput("reset_fruit_on", 32'(fruit_on), 7);
        checkOutput("reset_freeze", 32'(freeze), 1);
        checkOutput("reset_death_victory", 32'({death, victory, respawn, ghost_eaten}), 0);

        tickIdle(READY_FRAMES - 1);
        checkOutput("ready_freeze_last", 32'(freeze), 1);
        tickIdle(1);
        checkOutput("ready_to_play", 32'(freeze), 0);

        applyStimulus(1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 0);
        checkOutput("fruit2_on", 32'(fruit_on), 5);
        checkOutput("fruit2_reversal", 32'(reversal), 1);
        tickIdle(POWER_FRAMES - 1);
        checkOutput("power_hold", 32'(reversal), 1);
        tickIdle(1);
        checkOutput("power_end", 32'(reversal), 0);
        checkOutput("power_end_ghosts", 32'(ghost_enable), 7);

        applyStimulus(1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 0);
        checkOutput("fruit3_on", 32'(fruit_on), 1);
        applyStimulus(1'b1, 1'b0, 3'b101, 3'b000, 1'b0, 0);
        checkOutput("eat_ghosts", 32'(ghost_enable), 2);
        checkOutput("eat_pulse", 32'(ghost_eaten), 1);
        checkOutput("eat_lives", 32'(lives), 2);
        applyStimulus(1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 0);
        checkOutput("eat_pulse_width", 32'(ghost_eaten), 0);
        tickIdle(588);
        applyStimulus(1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 0);
        checkOutput("reload_fruit_on", 32'(fruit_on), 0);
        tickIdle(POWER_FRAMES - 1);
        checkOutput("reload_hold", 32'(reversal), 1);
        tickIdle(1);
        checkOutput("reload_end", 32'(reversal), 0);
        checkOutput("reload_end_ghosts", 32'(ghost_enable), 7);

        for (int life = 2; life >= 0; life--) begin
            applyStimulus(1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 0);
            checkOutput("hit_freeze", 32'(freeze), 1);
            tickIdle(DYING_FRAMES - 1);
            checkOutput("dying_no_respawn", 32'(respawn), 0);
            tickIdle(1);
            if (life > 0) begin
                checkOutput("respawn_pulse", 32'(respawn), 1);
                checkOutput("respawn_lives", 32'(lives), life - 1);
                applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 0);
                checkOutput("respawn_width", 32'(respawn), 0);
                tickIdle(READY_FRAMES);
                checkOutput("respawn_play", 32'(freeze), 0);
            end else begin
                checkOutput("gameover_death", 32'(death), 1);
                checkOutput("gameover_lives", 32'(lives), 0);
            end
        end
        tickIdle(1000);
        checkOutput("gameover_held", 32'({death, freeze}), 3);

        doReset();
        tickIdle(READY_FRAMES);
        applyStimulus(1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 150);
        checkOutput("win_victory", 32'(victory), 1);
        checkOutput("win_no_death", 32'(death), 0);
        checkOutput("win_lives", 32'(lives), 2);
        tickIdle(50);
        checkOutput("win_held", 32'(victory), 1);

        doReset();
        tickIdle(READY_FRAMES);
        applyStimulus(1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 0);
        tickIdle(299);
        applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 0);
        checkOutput("midreset_outs", 32'({lives, reversal, ghost_enable, fruit_on, freeze}), 32'b10_0_111_111_1);
        tickIdle(READY_FRAMES - 1);
        checkOutput("midreset_ready_hold", 32'(freeze), 1);
        tickIdle(1);
        checkOutput("midreset_ready_end", 32'(freeze), 0);

        doReset();
        for (int i = 0; i < 15000; i++) begin
            logic       t, rst, d;
            logic [2:0] g, f;
            int         sc;
            t   = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 599) == 0);
            g   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            f   = ($urandom_range(0, 40) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            d   = ($urandom_range(0, 2999) == 0);
            sc  = ($urandom_range(0, 2999) == 0) ? int'($urandom_range(150, 2047)) : int'($urandom_range(0, 149));
            applyStimulus(t, rst, g, f, d, sc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
